// File: rtl/bundle_skid_rx.sv
// bundle_skid_rx: two-entry receive register slice (OUT + SKID) with a
// valid/ready handshake. Upstream ready (o1) comes straight from a flop, so
// downstream backpressure never forms a combinational path to the producer.
// Optional feature macro: SKID_PARITY_CHK_EN adds i6 (even parity over i4)
// and o5 (sticky parity error flag).
module bundle_skid_rx #(
   parameter int unsigned W = 32
) (
   input  logic         i1,   // clock
   input  logic         i2,   // async reset, active low
   input  logic         i3,   // upstream valid
   input  logic [W-1:0] i4,   // upstream data
   input  logic         i5,   // downstream ready
   output logic         o1,   // upstream ready (registered)
   output logic         o2,   // downstream valid
   output logic [W-1:0] o3,   // downstream data
   output logic [1:0]   o4    // occupancy 0..2
`ifdef SKID_PARITY_CHK_EN
   ,
   input  logic         i6,   // upstream even-parity bit over i4
   output logic         o5    // sticky parity error
`endif
);

   // Encoding equals the occupancy so the state drives o4 directly.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t       state_q;
   logic [W-1:0] out_q;
   logic [W-1:0] skid_q;
   logic         rdy_q;
   logic         vld_q;

   logic         accept;
   logic         pop;

   assign accept = i3 & rdy_q;
   assign pop    = vld_q & i5;

   assign o1 = rdy_q;
   assign o2 = vld_q;
   assign o3 = out_q;
   assign o4 = state_q;

   // Occupancy FSM with registered ready/valid; OUT and SKID only load on the listed transitions.
   always_ff @(posedge i1 or negedge i2) begin
      if (!i2) begin
         state_q <= EMPTY;
         out_q   <= '0;
         skid_q  <= '0;
         rdy_q   <= 1'b1;
         vld_q   <= 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  out_q   <= i4;
                  state_q <= ONE;
                  vld_q   <= 1'b1;
                  rdy_q   <= 1'b1;
               end
            end
            ONE: begin
               if (accept && !pop) begin
                  skid_q  <= i4;
                  state_q <= TWO;
                  rdy_q   <= 1'b0;
               end else if (accept && pop) begin
                  out_q   <= i4;
               end else if (pop) begin
                  state_q <= EMPTY;
                  vld_q   <= 1'b0;
               end
            end
            TWO: begin
               // rdy_q is low here, so no accept can coincide with this pop.
               if (pop) begin
                  out_q   <= skid_q;
                  state_q <= ONE;
                  rdy_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= EMPTY;
               vld_q   <= 1'b0;
               rdy_q   <= 1'b1;
            end
         endcase
      end
   end

`ifdef SKID_PARITY_CHK_EN
   logic perr_q;
   logic perr_d;

   assign perr_d = perr_q | (accept & (^{i4, i6}));
   assign o5     = perr_q;

   // Sticky parity error: set on any accepted word with odd total parity, cleared only by reset.
   always_ff @(posedge i1 or negedge i2) begin
      if (!i2) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= perr_d;
      end
   end
`endif

endmodule

// File: tb/tb_bundle_skid_rx.sv
// Self-checking bench for bundle_skid_rx: directed vector table, a mid-transfer
// reset sequence, a randomized FIFO-order scoreboard run and, when
// SKID_PARITY_CHK_EN is defined, the sticky parity flag.
module tb_bundle_skid_rx;

   localparam int unsigned W = 16;

   logic         clk;
   logic         rst_n;
   logic         in_vld;
   logic [W-1:0] in_dat;
   logic         out_rdy;
   logic         in_rdy;
   logic         out_vld;
   logic [W-1:0] out_dat;
   logic [1:0]   occ;
`ifdef SKID_PARITY_CHK_EN
   logic         in_par;
   logic         perr;
`endif

   int unsigned vectors;
   int unsigned miscompares;

   bundle_skid_rx #(.W(W)) dut (
      .i1 (clk),
      .i2 (rst_n),
      .i3 (in_vld),
      .i4 (in_dat),
      .i5 (out_rdy),
      .o1 (in_rdy),
      .o2 (out_vld),
      .o3 (out_dat),
      .o4 (occ)
`ifdef SKID_PARITY_CHK_EN
      ,
      .i6 (in_par),
      .o5 (perr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         v;
      logic [W-1:0] d;
      logic         r;
      logic         e_rdy;
      logic         e_vld;
      logic [W-1:0] e_dat;
      logic [1:0]   e_occ;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
         miscompares++;
      end
   endtask

   task automatic set_in(input logic v, input logic [W-1:0] d, input logic r);
      in_vld  = v;
      in_dat  = d;
      out_rdy = r;
`ifdef SKID_PARITY_CHK_EN
      in_par  = ^d;
`endif
   endtask

   task automatic step(input logic v, input logic [W-1:0] d, input logic r);
      @(negedge clk);
      set_in(v, d, r);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic e_rdy, input logic e_vld,
                          input logic [W-1:0] e_dat, input logic [1:0] e_occ);
      vectors++;
      chk({tag, ".o1"}, 32'(in_rdy), 32'(e_rdy));
      chk({tag, ".o2"}, 32'(out_vld), 32'(e_vld));
      chk({tag, ".o3"}, 32'(out_dat), 32'(e_dat));
      chk({tag, ".o4"}, 32'(occ), 32'(e_occ));
   endtask

   logic [W-1:0] q[$];
   logic         pend;
   logic [W-1:0] pdata;
   logic [W-1:0] seq;

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      set_in(1'b0, '0, 1'b0);

      //          v  d        r  rdy vld dat      occ
      tbl[0]  = '{1, 16'h11, 1, 1,  1,  16'h11, 2'd1};  // streaming
      tbl[1]  = '{1, 16'h22, 1, 1,  1,  16'h22, 2'd1};
      tbl[2]  = '{1, 16'h33, 1, 1,  1,  16'h33, 2'd1};
      tbl[3]  = '{0, 16'h00, 1, 1,  0,  16'h33, 2'd0};  // drain keeps last word
      tbl[4]  = '{1, 16'hA1, 0, 1,  1,  16'hA1, 2'd1};  // fill under stall
      tbl[5]  = '{1, 16'hA2, 0, 0,  1,  16'hA1, 2'd2};
      tbl[6]  = '{1, 16'hA3, 0, 0,  1,  16'hA1, 2'd2};  // A3 held off
      tbl[7]  = '{1, 16'hA3, 1, 1,  1,  16'hA2, 2'd1};  // release: SKID->OUT
      tbl[8]  = '{1, 16'hA3, 1, 1,  1,  16'hA3, 2'd1};  // A3 accepted with pop
      tbl[9]  = '{0, 16'h00, 1, 1,  0,  16'hA3, 2'd0};
      tbl[10] = '{0, 16'h00, 1, 1,  0,  16'hA3, 2'd0};
      tbl[11] = '{1, 16'h05, 0, 1,  1,  16'h05, 2'd1};  // OUT=5
      tbl[12] = '{1, 16'h06, 1, 1,  1,  16'h06, 2'd1};  // accept+pop in ONE
      tbl[13] = '{0, 16'h00, 0, 1,  1,  16'h06, 2'd1};

      // Reset state
      #12;
      chk_all("reset", 1'b1, 1'b0, '0, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].r);
         chk_all($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_vld, tbl[i].e_dat, tbl[i].e_occ);
      end

      // Reset asserted between edges while full
      step(1'b1, 16'h07, 1'b0);
      chk_all("pre_rst", 1'b0, 1'b1, 16'h06, 2'd2);
      @(negedge clk);
      #2;
      set_in(1'b1, 16'h55, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 1'b1, 1'b0, '0, 2'd0);
      @(posedge clk);
      #1;
      chk_all("rst_hold", 1'b1, 1'b0, '0, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;
      set_in(1'b0, '0, 1'b0);
      step(1'b1, 16'h99, 1'b0);
      chk_all("post_rst1", 1'b1, 1'b1, 16'h99, 2'd1);
      step(1'b1, 16'h9A, 1'b0);
      chk_all("post_rst2", 1'b0, 1'b1, 16'h99, 2'd2);
      step(1'b0, '0, 1'b1);
      chk_all("post_rst3", 1'b1, 1'b1, 16'h9A, 2'd1);
      step(1'b0, '0, 1'b1);
      chk_all("post_rst4", 1'b1, 1'b0, 16'h9A, 2'd0);

      // Randomized traffic against a queue model
      pend = 1'b0;
      pdata = '0;
      seq = 16'h1000;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (!pend && ($urandom_range(0, 3) != 0)) begin
            pend  = 1'b1;
            pdata = seq;
            seq   = seq + 16'h1;
         end
         set_in(pend && (c < 380), pdata, ($urandom_range(0, 9) < 6) || (c >= 380));
         #1;
         vectors++;
         chk("rnd.o4", 32'(occ), 32'(q.size()));
         chk("rnd.o1", 32'(in_rdy), 32'(q.size() != 2));
         chk("rnd.o2", 32'(out_vld), 32'(q.size() != 0));
         if (out_vld && out_rdy) begin
            if (q.size() == 0) begin
               $display("FAIL rnd.pop: got %0h expected none", out_dat);
               miscompares++;
            end else begin
               chk("rnd.o3", 32'(out_dat), 32'(q.pop_front()));
            end
         end
         if (in_vld && in_rdy) begin
            q.push_back(pdata);
            pend = 1'b0;
         end
      end
      @(negedge clk);
      set_in(1'b0, '0, 1'b0);
      vectors++;
      chk("rnd.drained", 32'(q.size()), 32'd0);
      chk("rnd.final_o4", 32'(occ), 32'd0);

`ifdef SKID_PARITY_CHK_EN
      // Parity flag: bad word sets it, good words leave it set, reset clears it
      vectors++;
      chk("par.clear", 32'(perr), 32'd0);
      @(negedge clk);
      in_vld  = 1'b1;
      in_dat  = 16'h0003;
      in_par  = 1'b1;
      out_rdy = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      chk("par.set", 32'(perr), 32'd1);
      chk("par.data", 32'(out_dat), 32'h3);
      step(1'b1, 16'h0005, 1'b1);
      step(1'b0, '0, 1'b1);
      vectors++;
      chk("par.sticky", 32'(perr), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++;
      chk("par.rst", 32'(perr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
